// File: rtl/spi_frame_pkg.sv
// Shared widths, FSM state encoding and sizing helpers for the SPI frame master/slave pair.
package spi_frame_pkg;

   localparam int IDX_W_DEF  = 4;
   localparam int DATA_W_DEF = 28;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SETUP = 3'd1;
   localparam state_t ST_SHIFT = 3'd2;
   localparam state_t ST_HOLD  = 3'd3;
   localparam state_t ST_GAP   = 3'd4;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_frame_fifo.sv
// Synchronous FIFO with registered full/empty flags; push and pop may coincide at any fill level.
module spi_frame_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   // A pop frees the slot that a simultaneous push into a full FIFO needs.
   assign do_pop  = pop_i & ~empty_q;
   assign do_push = push_i & (~full_q | do_pop);

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop)
         cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == FULL_CNT);
         empty_q <= (cnt_d == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push)
         mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: shifts {index,data} out, captures the response, routes it to status or RX FIFO.
// Optional feature macro: SPI_FRAME_MASTER_STATUS_EN (index-0 responses feed the status shadow).
module spi_frame_master
   import spi_frame_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int IDX_W      = IDX_W_DEF,
   parameter int CLK_DIV    = 2,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 2,
   parameter int CS_GAP     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   input  logic [IDX_W-1:0]  tx_index_i,
   input  logic [DATA_W-1:0] tx_data_i,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic [IDX_W-1:0]  rx_index_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic [DATA_W-1:0] status_o,
   output logic              status_changed_o,
   output logic              rx_overflow_o,
   input  logic              ovf_clr_i,
   output logic              busy_o,
   output logic              spi_clk_o,
   output logic              spi_mosi_o,
   input  logic              spi_miso_i,
   output logic              spi_cs_o
);

   localparam int FRAME_W = IDX_W + DATA_W;
   localparam int TMAX    = max2(max2(CLK_DIV, CS_SETUP), max2(CS_HOLD, CS_GAP));
   localparam int TW      = $clog2(TMAX + 1);
   localparam int BW      = $clog2(FRAME_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);

   state_t               state_q, state_d;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [FRAME_W-1:0]   tx_sh_q, tx_sh_d;
   logic [FRAME_W-1:0]   rx_sh_q, rx_sh_d;
   logic                 sclk_q, sclk_d;
   logic                 cs_q, cs_d;
   logic                 dec_q, dec_d;
   logic                 tx_ready_q, busy_q, ovf_q;

   logic [IDX_W-1:0]     rx_idx;
   logic [DATA_W-1:0]    rx_dat;
   logic                 is_stat, push, drop;
   logic                 fifo_full, fifo_empty;
   logic [FRAME_W-1:0]   fifo_rdata;

   // One timer serves the CS setup/hold/gap waits and the SCLK half-period divider,
   // since those phases never overlap.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      bit_d   = bit_q;
      tx_sh_d = tx_sh_q;
      rx_sh_d = rx_sh_q;
      sclk_d  = sclk_q;
      cs_d    = cs_q;
      dec_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tx_valid_i && tx_ready_q) begin
               tx_sh_d = {tx_index_i, tx_data_i};
               cs_d    = 1'b0;
               tmr_d   = TW'(CS_SETUP - 1);
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_q == '0) begin
               tmr_d   = TW'(CLK_DIV - 1);
               bit_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         ST_SHIFT: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - 1'b1;
            end else begin
               tmr_d = TW'(CLK_DIV - 1);
               if (!sclk_q) begin
                  sclk_d  = 1'b1;
                  rx_sh_d = {rx_sh_q[FRAME_W-2:0], spi_miso_i};
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == LAST_BIT) begin
                     tmr_d   = TW'(CS_HOLD - 1);
                     dec_d   = 1'b1;
                     state_d = ST_HOLD;
                  end else begin
                     bit_d   = bit_q + 1'b1;
                     tx_sh_d = {tx_sh_q[FRAME_W-2:0], 1'b0};
                  end
               end
            end
         end
         ST_HOLD: begin
            if (tmr_q == '0) begin
               cs_d    = 1'b1;
               tmr_d   = TW'(CS_GAP - 1);
               state_d = ST_GAP;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (tmr_q == '0)
               state_d = ST_IDLE;
            else
               tmr_d = tmr_q - 1'b1;
         end
         default: begin
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         tmr_q      <= '0;
         bit_q      <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         sclk_q     <= 1'b0;
         cs_q       <= 1'b1;
         dec_q      <= 1'b0;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         bit_q      <= bit_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         sclk_q     <= sclk_d;
         cs_q       <= cs_d;
         dec_q      <= dec_d;
         tx_ready_q <= (state_d == ST_IDLE);
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   // dec_q marks the first HOLD cycle, when rx_sh_q holds the complete response.
   assign rx_idx = rx_sh_q[FRAME_W-1 -: IDX_W];
   assign rx_dat = rx_sh_q[DATA_W-1:0];

`ifdef SPI_FRAME_MASTER_STATUS_EN
   assign is_stat = (rx_idx == '0);
`else
   assign is_stat = 1'b0;
`endif

   assign push = dec_q & ~is_stat;
   assign drop = push & fifo_full & ~rx_ready_i;

   spi_frame_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FRAME_W)
   ) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push),
      .wdata_i (rx_sh_q),
      .pop_i   (rx_ready_i),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i)
         ovf_q <= 1'b0;
      else if (drop)
         ovf_q <= 1'b1;
      else if (ovf_clr_i)
         ovf_q <= 1'b0;
   end

`ifdef SPI_FRAME_MASTER_STATUS_EN
   logic [DATA_W-1:0] status_q;
   logic              status_chg_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         status_q     <= '0;
         status_chg_q <= 1'b0;
      end else begin
         status_chg_q <= 1'b0;
         if (dec_q && is_stat) begin
            status_q     <= rx_dat;
            status_chg_q <= (rx_dat != status_q);
         end
      end
   end

   assign status_o         = status_q;
   assign status_changed_o = status_chg_q;
`else
   assign status_o         = '0;
   assign status_changed_o = 1'b0;
`endif

   assign tx_ready_o    = tx_ready_q;
   assign busy_o        = busy_q;
   assign spi_cs_o      = cs_q;
   assign spi_clk_o     = sclk_q;
   assign spi_mosi_o    = tx_sh_q[FRAME_W-1];
   assign rx_valid_o    = ~fifo_empty;
   assign rx_index_o    = fifo_rdata[FRAME_W-1 -: IDX_W];
   assign rx_data_o     = fifo_rdata[DATA_W-1:0];
   assign rx_overflow_o = ovf_q;

endmodule

// File: doc/spi_frame_master.md
# spi_frame_master

Synthesizable SPI master for the Jetson-side link: it shifts framed words (index + data) out on MOSI and simultaneously captures the slave's response frame from MISO. It decodes the response index, tracks index 0 as a status shadow register, and queues all other responses in an RX FIFO for the host logic. It generalises the fixed 4+28-bit, single-stream transfer to parametrised index/data widths, programmable SCLK timing, and a buffered RX path with overflow reporting.

## Interface
- DATA_W, 28, payload bits per frame
- IDX_W, 4, index (channel) bits per frame; FRAME_W = IDX_W + DATA_W
- CLK_DIV, 2, clk cycles per SCLK half-period (≥1)
- CS_SETUP, 2, clk cycles from CS fall to first SCLK edge (≥1)
- CS_HOLD, 2, clk cycles from last SCLK fall to CS rise (≥1)
- CS_GAP, 4, minimum clk cycles CS stays high between frames (≥1)
- FIFO_DEPTH, 4, RX FIFO entries (power of two, ≥2)
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tx_valid  in  1  request frame
- tx_ready  out  1  frame accepted when tx_valid & tx_ready
- tx_index  in  IDX_W  outgoing index
- tx_data  in  DATA_W  outgoing payload
- rx_valid  out  1  RX FIFO head valid
- rx_ready  in  1  pop RX FIFO head
- rx_index  out  IDX_W  response index at head
- rx_data  out  DATA_W  response payload at head
- status  out  DATA_W  shadow of last index-0 payload
- status_changed  out  1  one-cycle pulse when status value changes
- rx_overflow  out  1  sticky: response dropped, FIFO full
- ovf_clr  in  1  clears rx_overflow
- busy  out  1  CS low or gap in progress
- spi_clk  out  1  SCLK, mode 0 (idle low)
- spi_mosi  out  1  MSB-first serial out
- spi_miso  in  1  serial in
- spi_cs  out  1  active-low chip select

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: tx_ready=1. On accept, latch {tx_index, tx_data} into the shift register, drive spi_cs=0, go to SETUP. MOSI presents bit FRAME_W-1 immediately.
- SETUP: wait CS_SETUP cycles, then go to SHIFT.
- SHIFT: FRAME_W SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
  - On the cycle SCLK rises, sample spi_miso into the RX shift register LSB.
  - On each SCLK fall, except after the last bit, shift TX left so MOSI shows the next bit.
  - After the last high phase, SCLK returns low; go to HOLD.
- HOLD: wait CS_HOLD cycles. On HOLD entry, decode RX frame: index = bits [FRAME_W-1:DATA_W], data = low DATA_W bits.
  - Index 0 (with STATUS_EN): load status; pulse status_changed if the new value differs. Not queued.
  - Other index: push to FIFO. If full and not popped the same cycle: drop, set rx_overflow.
  - On HOLD exit, spi_cs=1; go to GAP.
- GAP: wait CS_GAP cycles, then IDLE.
- tx_ready is 0 outside IDLE. busy = (state != IDLE).
- rx_overflow: set has priority over ovf_clr in the same cycle.
- FIFO: push and pop in the same cycle are legal at any fill level, including full.

## Timing
- Reset values: spi_cs=1, spi_clk=0, spi_mosi=0, tx_ready=0 during reset and 1 on the first cycle after, rx_valid=0, status=0, status_changed=0, rx_overflow=0, busy=0. FIFO empty.
- Default frame: CS low for CS_SETUP + FRAME_W·2·CLK_DIV + CS_HOLD = 2+128+2 = 132 cycles. Accept-to-accept minimum is 1+132+4 = 137 cycles.
- rx_valid rises on the cycle after HOLD entry. status and status_changed update on that same cycle.
- All outputs are registered; no combinational path from spi_miso to any output.
- rst_n low mid-frame: next edge forces IDLE, spi_cs=1, spi_clk=0. The partial frame is discarded and FIFO and status are cleared.

## Configuration
- SPI_FRAME_MASTER_STATUS_EN defined: index-0 responses update status/status_changed and bypass the FIFO.
- Not defined: status=0 and status_changed=0 are constant; index-0 responses are queued like any other index.

## Structure
- Package spi_frame_pkg holds the default widths (IDX_W=4, DATA_W=28) and the state-encoding typedef.
- Sub-module spi_frame_fifo: parametrised synchronous FIFO (DEPTH, WIDTH=FRAME_W) with full/empty flags and simultaneous push/pop. Also reusable on the slave side.

## Test plan
- Loopback (MISO=MOSI), send idx 3 / 0x0ABCDEF: MOSI shows 0x30ABCDEF MSB-first; rx pops idx 3, data 0x0ABCDEF; CS low exactly 132 cycles.
- Slave model returns 0x00000055, then 0x00000055 again: status=0x55; status_changed pulses once; rx_valid stays 0. Without macro: two FIFO entries with idx 0.
- Six back-to-back idx-5 frames with rx_ready=0: first four queued, rx_overflow=1 after the fifth; ovf_clr clears it; FIFO still holds four entries.
- FIFO full, rx_ready=1 held during the frame's decode cycle: push and pop both succeed, no overflow.
- rst_n asserted at bit 10 of SHIFT: next cycle spi_cs=1, spi_clk=0, rx_valid=0; a new frame afterwards completes correctly.
- CLK_DIV=1, CS_GAP=1, tx_valid held high: accept-to-accept spacing = 1+2+64+2+1 = 70 cycles; SCLK period 2 cycles.
